// File: rtl/tky_pkg.sv
// Shared types and helpers for the tweakey update block.
// The RDBK state exists only when TKY_READBACK_EN is defined.
package tky_pkg;

    localparam int BUS_W_8  = 8;
    localparam int BUS_W_16 = 16;
    localparam int BUS_W_32 = 32;
    localparam int BUS_W_64 = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY
`ifdef TKY_READBACK_EN
        ,
        ST_RDBK
`endif
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_SHIFT,
        OP_ENC,
        OP_DEC
    } word_op_t;

    function automatic int calc_nw(input int tk_w, input int bus_w);
        return tk_w / bus_w;
    endfunction

    function automatic bit bus_w_legal(input int w);
        return (w == BUS_W_8) || (w == BUS_W_16) || (w == BUS_W_32) || (w == BUS_W_64);
    endfunction

endpackage

// File: rtl/tky_word_reg.sv
// One BUS_W slice of the tweakey register: hold, shift-in, forward or inverse update.
module tky_word_reg
    import tky_pkg::*;
#(
    parameter int BUS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  word_op_t         op,
    input  logic [BUS_W-1:0] shift_in,
    input  logic [BUS_W-1:0] enc_in,
    input  logic [BUS_W-1:0] dec_in,
    output logic [BUS_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (op)
                OP_SHIFT: q <= shift_in;
                OP_ENC:   q <= enc_in;
                OP_DEC:   q <= dec_in;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/tky_update_param.sv
// Tweakey register with serial load, per-round forward/inverse update and, when
// TKY_READBACK_EN is defined, a non-destructive rotating readback port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no valid key; enc/dec ignored
// LOAD     | accepting NW words, each shifts tky up one word
// READY    | full key present; enc/dec update tky
// RDBK     | key rotates out one word per pdo beat, restored after NW beats
module tky_update_param
    import tky_pkg::*;
#(
    parameter int BUS_W = 32,
    parameter int TK_W  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_load,
    input  logic [BUS_W-1:0] pdi_data,
    input  logic             pdi_valid,
    output logic             pdi_ready,
    input  logic             enc,
    input  logic             dec,
    input  logic [TK_W-1:0]  skinny_tky,
    input  logic [TK_W-1:0]  skinny_tky_revert,
    output logic [TK_W-1:0]  tky,
    output logic             loaded
`ifdef TKY_READBACK_EN
    ,
    input  logic             rd_start,
    output logic [BUS_W-1:0] pdo_data,
    output logic             pdo_valid,
    input  logic             pdo_ready
`endif
);

    localparam int NW    = calc_nw(TK_W, BUS_W);
    localparam int CNT_W = $clog2(NW + 1);

    if (!bus_w_legal(BUS_W) || (TK_W % BUS_W) != 0 || NW < 1) begin : g_bad_cfg
        $error("tky_update_param: illegal BUS_W/TK_W combination");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    word_op_t         op;
    logic [BUS_W-1:0] word0_in;
    logic [BUS_W-1:0] top_word;
    logic             last_beat;

    assign top_word  = tky[TK_W-1 -: BUS_W];
    assign last_beat = (cnt == CNT_W'(NW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter only advances on the beat that can still be below NW, so it saturates at NW.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (start_load) begin
            state_nxt = ST_LOAD;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (pdi_valid) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (last_beat) state_nxt = ST_READY;
                    end
                end
`ifdef TKY_READBACK_EN
                ST_READY: begin
                    if (rd_start) begin
                        state_nxt = ST_RDBK;
                        cnt_nxt   = '0;
                    end
                end
                ST_RDBK: begin
                    if (pdo_ready) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (last_beat) state_nxt = ST_READY;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        pdi_ready = (state == ST_LOAD);
        loaded    = (state == ST_READY);
        op        = OP_HOLD;
        word0_in  = pdi_data;
`ifdef TKY_READBACK_EN
        pdo_valid = (state == ST_RDBK);
        pdo_data  = (state == ST_RDBK) ? top_word : '0;
`endif
        if (!start_load) begin
            case (state)
                ST_LOAD: begin
                    if (pdi_valid) op = OP_SHIFT;
                end
                ST_READY: begin
                    if (enc)      op = OP_ENC;
                    else if (dec) op = OP_DEC;
`ifdef TKY_READBACK_EN
                    if (rd_start) op = OP_HOLD;
`endif
                end
`ifdef TKY_READBACK_EN
                // Rotation reuses the load shift path with the top word fed back into word 0.
                ST_RDBK: begin
                    if (pdo_ready) begin
                        op       = OP_SHIFT;
                        word0_in = top_word;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NW; k++) begin : g_word
        logic [BUS_W-1:0] shift_in;
        if (k == 0) begin : g_first
            assign shift_in = word0_in;
        end else begin : g_rest
            assign shift_in = tky[(k-1)*BUS_W +: BUS_W];
        end
        tky_word_reg #(.BUS_W(BUS_W)) u_word (
            .clk      (clk),
            .rst      (rst),
            .op       (op),
            .shift_in (shift_in),
            .enc_in   (skinny_tky[k*BUS_W +: BUS_W]),
            .dec_in   (skinny_tky_revert[k*BUS_W +: BUS_W]),
            .q        (tky[k*BUS_W +: BUS_W])
        );
    end

endmodule

// File: tb/tb_tky_update_param.sv
// Scoreboard bench for tky_update_param: a word-level key model pushes expected
// state each cycle; a negedge monitor pops and compares. Readback is covered when TKY_READBACK_EN is defined.
module tb_tky_update_param;

    localparam int BUS_W = 32;
    localparam int TK_W  = 128;
    localparam int NW    = TK_W / BUS_W;
    localparam int B8    = 8;
    localparam int T8    = 384;
    localparam int NW8   = T8 / B8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start_load, pdi_valid, pdi_ready, enc, dec, loaded;
    logic [BUS_W-1:0] pdi_data;
    logic [TK_W-1:0]  skinny_tky, skinny_tky_revert, tky;
`ifdef TKY_READBACK_EN
    logic             rd_start, pdo_valid, pdo_ready;
    logic [BUS_W-1:0] pdo_data;
    logic             rd_start8, pdo_valid8, pdo_ready8;
    logic [B8-1:0]    pdo_data8;
`endif

    logic             start_load8, pdi_valid8, pdi_ready8, enc8, dec8, loaded8;
    logic [B8-1:0]    pdi_data8;
    logic [T8-1:0]    sk8, skr8, tky8;

    tky_update_param #(.BUS_W(BUS_W), .TK_W(TK_W)) dut (
        .clk(clk), .rst(rst), .start_load(start_load), .pdi_data(pdi_data),
        .pdi_valid(pdi_valid), .pdi_ready(pdi_ready), .enc(enc), .dec(dec),
        .skinny_tky(skinny_tky), .skinny_tky_revert(skinny_tky_revert),
        .tky(tky), .loaded(loaded)
`ifdef TKY_READBACK_EN
        , .rd_start(rd_start), .pdo_data(pdo_data), .pdo_valid(pdo_valid), .pdo_ready(pdo_ready)
`endif
    );

    tky_update_param #(.BUS_W(B8), .TK_W(T8)) dut8 (
        .clk(clk), .rst(rst), .start_load(start_load8), .pdi_data(pdi_data8),
        .pdi_valid(pdi_valid8), .pdi_ready(pdi_ready8), .enc(enc8), .dec(dec8),
        .skinny_tky(sk8), .skinny_tky_revert(skinny_tky_revert8_w()),
        .tky(tky8), .loaded(loaded8)
`ifdef TKY_READBACK_EN
        , .rd_start(rd_start8), .pdo_data(pdo_data8), .pdo_valid(pdo_valid8), .pdo_ready(pdo_ready8)
`endif
    );

    function automatic logic [T8-1:0] skinny_tky_revert8_w();
        return skr8;
    endfunction

    typedef struct {
        logic [TK_W-1:0] key;
        bit              chk_key;
        bit              loaded;
        bit              pdi_ready;
        bit              pdo_valid;
    } snap_t;

    snap_t            snap_q[$];
    logic [BUS_W-1:0] pdo_q[$];
    int               checks = 0;
    int               errors = 0;

    // Model: mode 0 = no key, 1 = loading, 2 = key ready, 3 = reading back.
    int               mode  = 0;
    int               beats = 0;
    logic [TK_W-1:0]  mkey  = '0;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [383:0] rnd_wide();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void model_step();
        if (rst) begin
            mode = 0; beats = 0; mkey = '0;
        end else if (start_load) begin
            mode = 1; beats = 0;
        end else begin
            case (mode)
                1: if (pdi_valid) begin
                    mkey = {mkey[TK_W-BUS_W-1:0], pdi_data};
                    beats++;
                    if (beats == NW) mode = 2;
                end
                2: begin
`ifdef TKY_READBACK_EN
                    if (rd_start) begin
                        mode = 3; beats = 0;
                        for (int i = NW - 1; i >= 0; i--) pdo_q.push_back(mkey[i*BUS_W +: BUS_W]);
                    end else
`endif
                    if (enc)      mkey = skinny_tky;
                    else if (dec) mkey = skinny_tky_revert;
                end
`ifdef TKY_READBACK_EN
                3: if (pdo_ready) begin
                    beats++;
                    if (beats == NW) mode = 2;
                end
`endif
                default: ;
            endcase
        end
    endfunction

    // Inputs set now are taken at the next rising edge; snapshot is the model state after it.
    task automatic tick();
        snap_t s;
        model_step();
        @(posedge clk);
        #1;
        s.key       = mkey;
        s.chk_key   = (mode != 3);
        s.loaded    = (mode == 2);
        s.pdi_ready = (mode == 1);
        s.pdo_valid = (mode == 3);
        snap_q.push_back(s);
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clk);
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                if (s.chk_key) check("sb_tky", tky, s.key);
                check("sb_loaded", loaded, s.loaded);
                check("sb_pdi_ready", pdi_ready, s.pdi_ready);
`ifdef TKY_READBACK_EN
                check("sb_pdo_valid", pdo_valid, s.pdo_valid);
`endif
            end
`ifdef TKY_READBACK_EN
            if (pdo_valid && pdo_ready) begin
                if (pdo_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pdo_unexpected: got beat %0h expected no beat", pdo_data);
                end else begin
                    check("sb_pdo_data", pdo_data, pdo_q.pop_front());
                end
            end
`endif
        end
    end

    logic [BUS_W-1:0] kw [NW];
    localparam logic [TK_W-1:0] KEY_REF = 128'h000102030405060708090A0B0C0D0E0F;

    task automatic load_key(input int stall_after, input int stall_len);
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        for (int i = 0; i < NW; i++) begin
            pdi_valid  = 1'b1;
            pdi_data   = kw[i];
            enc        = 1'($urandom);
            dec        = 1'($urandom);
            skinny_tky = rnd_wide()[TK_W-1:0];
            tick();
            if (i == stall_after) begin
                pdi_valid = 1'b0;
                pdi_data  = $urandom;
                repeat (stall_len) tick();
            end
        end
        pdi_valid = 1'b0;
        enc = 1'b0;
        dec = 1'b0;
    endtask

    initial begin : stim
        logic [T8-1:0] key8;
        rst = 1'b1; start_load = 1'b0; pdi_valid = 1'b0; pdi_data = '0;
        enc = 1'b0; dec = 1'b0; skinny_tky = '0; skinny_tky_revert = '0;
        start_load8 = 1'b0; pdi_valid8 = 1'b0; pdi_data8 = '0;
        enc8 = 1'b0; dec8 = 1'b0; sk8 = '0; skr8 = '0;
`ifdef TKY_READBACK_EN
        rd_start = 1'b0; pdo_ready = 1'b0; rd_start8 = 1'b0; pdo_ready8 = 1'b0;
`endif
        kw[0] = 32'h00010203; kw[1] = 32'h04050607; kw[2] = 32'h08090A0B; kw[3] = 32'h0C0D0E0F;

        repeat (3) tick();
        check("reset_tky", tky, 0);
        check("reset_loaded", loaded, 0);
        rst = 1'b0;
        enc = 1'b1; skinny_tky = rnd_wide()[TK_W-1:0];
        tick();
        check("idle_enc_ignored", tky, 0);
        enc = 1'b0;

        load_key(-1, 0);
        check("load_tky", tky, KEY_REF);
        check("load_loaded", loaded, 1);

        load_key(1, 3);
        check("stall_load_tky", tky, KEY_REF);

        skinny_tky = {TK_W/8{8'hAA}}; skinny_tky_revert = {TK_W/8{8'h55}};
        enc = 1'b1; dec = 1'b1;
        tick();
        check("enc_priority", tky, {TK_W/8{8'hAA}});
        enc = 1'b0;
        tick();
        check("dec_only", tky, {TK_W/8{8'h55}});
        dec = 1'b0;

        start_load = 1'b1; tick(); start_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pdi_valid = 1'b1; pdi_data = kw[i]; tick();
        end
        pdi_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_tky", tky, 0);
        check("abort_loaded", loaded, 0);
        check("abort_pdi_ready", pdi_ready, 0);
        enc = 1'b1; skinny_tky = rnd_wide()[TK_W-1:0];
        repeat (3) tick();
        check("abort_enc_ignored", tky, 0);
        enc = 1'b0;

`ifdef TKY_READBACK_EN
        load_key(-1, 0);
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        enc = 1'b1; skinny_tky = rnd_wide()[TK_W-1:0];
        for (int c = 0; c < 200 && mode == 3; c++) begin
            pdo_ready = 1'($urandom);
            tick();
        end
        pdo_ready = 1'b0; enc = 1'b0;
        check("rdbk_restored", tky, KEY_REF);
        check("rdbk_loaded", loaded, 1);
        check("rdbk_drained", pdo_q.size(), 0);
`endif

        for (int c = 0; c < 500; c++) begin
            rst        = (mode != 3) && ($urandom_range(99) < 2);
            start_load = (mode != 3) && ($urandom_range(99) < 4);
            pdi_valid  = ($urandom_range(99) < 70);
            pdi_data   = $urandom;
            enc        = ($urandom_range(3) == 0);
            dec        = ($urandom_range(3) == 0);
            skinny_tky        = rnd_wide()[TK_W-1:0];
            skinny_tky_revert = rnd_wide()[TK_W-1:0];
`ifdef TKY_READBACK_EN
            rd_start  = ($urandom_range(99) < 5);
            pdo_ready = 1'($urandom);
`endif
            tick();
        end
        rst = 1'b0; start_load = 1'b0; pdi_valid = 1'b0; enc = 1'b0; dec = 1'b0;
`ifdef TKY_READBACK_EN
        rd_start = 1'b0; pdo_ready = 1'b1;
        for (int c = 0; c < 2 * NW && mode == 3; c++) tick();
        pdo_ready = 1'b0;
`endif
        tick();

        key8 = '0;
        start_load8 = 1'b1; tick(); start_load8 = 1'b0;
        for (int i = 0; i < NW8; i++) begin
            pdi_valid8 = 1'b1;
            pdi_data8  = $urandom;
            key8       = {key8[T8-B8-1:0], pdi_data8};
            tick();
            if (i == NW8 - 2) check("w8_not_loaded_before_last", loaded8, 0);
        end
        pdi_valid8 = 1'b0;
        check("w8_loaded", loaded8, 1);
        check("w8_tky", tky8, key8);
        sk8 = rnd_wide(); skr8 = rnd_wide(); enc8 = 1'b1;
        tick();
        enc8 = 1'b0;
        check("w8_enc_full_width", tky8, sk8);
        dec8 = 1'b1;
        tick();
        dec8 = 1'b0;
        check("w8_dec_full_width", tky8, skr8);

        repeat (2) tick();
        @(negedge clk);
        #1;
        check("pdo_queue_empty", pdo_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tky_update_param.md
TKY_UPDATE_PARAM -- requirements
Module: tky_update_param

Interface
REQ-001 Parameter BUS_W, default 32, SHALL set the load/readback word width (legal: 8, 16, 32, 64).
REQ-002 Parameter TK_W, default 128, SHALL set the tweakey width; it SHALL be an integer multiple of BUS_W; NW = TK_W/BUS_W.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start_load  in  1  begin a serial key load of NW words.
REQ-006 pdi_data  in  BUS_W  load word.
REQ-007 pdi_valid  in  1  load word valid.
REQ-008 pdi_ready  out  1  block accepts a load word.
REQ-009 enc  in  1  capture skinny_tky (forward round update).
REQ-010 dec  in  1  capture skinny_tky_revert (inverse round update).
REQ-011 skinny_tky  in  TK_W  next-round tweakey from the round function.
REQ-012 skinny_tky_revert  in  TK_W  previous-round tweakey from the inverse function.
REQ-013 tky  out  TK_W  current tweakey register.
REQ-014 loaded  out  1  level; full key present and updatable.
REQ-015 rd_start  in  1, pdo_data  out  BUS_W, pdo_valid  out  1, pdo_ready  in  1: readback port, present only under TKY_READBACK_EN.

Function
REQ-016 FSM states IDLE, LOAD, READY, and RDBK (RDBK only under TKY_READBACK_EN).
REQ-017 start_load in any state SHALL enter LOAD next cycle with word counter = 0 and loaded = 0; tky contents SHALL be unchanged until beats arrive.
REQ-018 In LOAD, pdi_ready SHALL be 1; elsewhere pdi_ready SHALL be 0.
REQ-019 Each beat (pdi_valid & pdi_ready) SHALL shift tky up one word (word k <= word k-1) with pdi_data into word 0, and increment the counter.
REQ-020 The beat that makes counter = NW SHALL move FSM to READY and assert loaded on the following cycle; first-loaded word ends in the top word.
REQ-021 Cycles in LOAD without pdi_valid SHALL hold tky and counter (stall).
REQ-022 In READY, enc = 1 SHALL load tky <= skinny_tky in one cycle; dec = 1 (enc = 0) SHALL load tky <= skinny_tky_revert.
REQ-023 enc and dec both 1 SHALL apply enc only.
REQ-024 enc/dec SHALL be ignored in IDLE, LOAD and RDBK.
REQ-025 Priority per cycle: rst > start_load > load beat > rd_start > enc > dec.
REQ-026 Counter width SHALL be clog2(NW+1); it SHALL never exceed NW.

Reset
REQ-027 On rst: tky = 0, state = IDLE, counter = 0, loaded = 0, pdi_ready = 0, pdo_valid = 0, pdo_data = 0.
REQ-028 rst asserted mid-LOAD or mid-RDBK SHALL abort the transfer with no partial-state retention.

Configuration
REQ-029 Macro TKY_READBACK_EN defined: rd_start in READY SHALL enter RDBK; tky rotates one word per accepted beat (pdo_valid & pdo_ready), top word presented on pdo_data and rotated into word 0; after NW beats return to READY with tky equal to its pre-readback value and loaded = 1.
REQ-030 In RDBK, pdo_valid SHALL be 1 and pdo_data stable while pdo_ready = 0.
REQ-031 Macro undefined: readback ports, RDBK state and their logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-032 Shared package tky_pkg SHALL hold the FSM state enum, the NW computation function and legal BUS_W constants.
REQ-033 One sub-module tky_word_reg (BUS_W register with load/shift/update/revert mux) SHALL be instantiated NW times via generate.

Verification (BUS_W = 32, TK_W = 128)
REQ-034 start_load, beats 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F -> tky = 0x000102030405060708090A0B0C0D0E0F, loaded = 1 one cycle after beat 4.
REQ-035 Same load with pdi_valid dropped 3 cycles after beat 2 -> identical final tky; counter holds at 2 during stall.
REQ-036 READY, skinny_tky = 0xAA..AA, skinny_tky_revert = 0x55..55, enc = dec = 1 -> tky = 0xAA..AA; next cycle dec only -> 0x55..55.
REQ-037 rst after beat 2 -> tky = 0, loaded = 0, pdi_ready = 0 next cycle; enc ignored afterwards.
REQ-038 TKY_READBACK_EN, key from REQ-034, rd_start, pdo_ready toggling -> pdo_data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F in order; tky restored, state READY.
REQ-039 BUS_W = 8, TK_W = 384 -> 48 beats load full key, loaded after beat 48, enc updates all 384 bits.
